// File: rtl/voter_tally_fsm_pkg.sv
// Shared types and helpers for the multi-cycle voter tally.
// Verdict encodings, FSM state enum and the tally-to-verdict function.
package voter_pkg;

    localparam logic [2:0] RES_NONE   = 3'b000;
    localparam logic [2:0] RES_REJECT = 3'b100;
    localparam logic [2:0] RES_TIE    = 3'b010;
    localparam logic [2:0] RES_PASS   = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        DECIDE,
        DONE
    } state_t;

    // Missing voters are implicitly "no": only the yes tally is compared.
    function automatic logic [2:0] verdict(
        input int unsigned yes,
        input int unsigned n
    );
        if (2 * yes > n) begin
            verdict = RES_PASS;
        end else if (2 * yes == n) begin
            verdict = RES_TIE;
        end else begin
            verdict = RES_REJECT;
        end
    endfunction

endpackage

// File: rtl/voter_tally_fsm_popcount.sv
// Counts yes ballots newly accepted this cycle.
// A ballot counts only if valid, yes, and from a voter not yet voted.
module voter_popcount #(
    parameter int N_VOTERS = 4,
    localparam int CNT_W = $clog2(N_VOTERS + 1)
) (
    input  logic [N_VOTERS-1:0] i_valid,
    input  logic [N_VOTERS-1:0] i_voted,
    input  logic [N_VOTERS-1:0] i_yes,
    output logic [CNT_W-1:0]    o_count
);

    logic [N_VOTERS-1:0] w_bits;

    assign w_bits = i_valid & ~i_voted & i_yes;

    always_comb begin
        o_count = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            o_count = o_count + CNT_W'(w_bits[i]);
        end
    end

endmodule

// File: rtl/voter_tally_fsm.sv
// Session-based voter tally: collects one ballot per voter, then
// issues a registered one-hot verdict with a one-cycle valid strobe.
module voter_tally_fsm #(
    parameter int N_VOTERS = 4,
    parameter int TIMEOUT = 16,
    localparam int CNT_W = $clog2(N_VOTERS + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [N_VOTERS-1:0] i_vote_valid,
    input  logic [N_VOTERS-1:0] i_vote_yes,
    output logic                o_busy,
    output logic [N_VOTERS-1:0] o_voted,
    output logic [CNT_W-1:0]    o_yes_count,
    output logic [2:0]          o_result,
    output logic                o_result_valid,
    output logic                o_timed_out
);

    import voter_pkg::*;

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t              r_state;
    logic [N_VOTERS-1:0] r_voted;
    logic [CNT_W-1:0]    r_yes_count;
    logic [TMR_W-1:0]    r_timer;
    logic [2:0]          r_result;
    logic                r_result_valid;
    logic                r_timed_out;

    logic [N_VOTERS-1:0] w_voted_nx;
    logic [CNT_W-1:0]    w_add;
    logic                w_all_voted;

    voter_popcount #(
        .N_VOTERS(N_VOTERS)
    ) u_popcount (
        .i_valid (i_vote_valid),
        .i_voted (r_voted),
        .i_yes   (i_vote_yes),
        .o_count (w_add)
    );

    assign w_voted_nx  = r_voted | i_vote_valid;
    assign w_all_voted = &w_voted_nx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_voted        <= '0;
            r_yes_count    <= '0;
            r_timer        <= '0;
            r_result       <= RES_NONE;
            r_result_valid <= 1'b0;
            r_timed_out    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state     <= OPEN;
                        r_voted     <= '0;
                        r_yes_count <= '0;
                        r_timer     <= '0;
                        r_timed_out <= 1'b0;
                        r_result    <= RES_NONE;
                    end
                end
                OPEN: begin
                    r_voted     <= w_voted_nx;
                    r_yes_count <= r_yes_count + w_add;
                    r_timer     <= r_timer + TMR_W'(1);
                    // All-voted wins over a coincident timeout.
                    if (w_all_voted) begin
                        r_state <= DECIDE;
                    end else if (r_timer == TMR_LAST) begin
                        r_state     <= DECIDE;
                        r_timed_out <= 1'b1;
                    end
                end
                DECIDE: begin
                    r_result       <= verdict(32'(r_yes_count), 32'(N_VOTERS));
                    r_result_valid <= 1'b1;
                    r_state        <= DONE;
                end
                DONE: begin
                    r_result_valid <= 1'b0;
                    r_state        <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy         = (r_state != IDLE);
    assign o_voted        = r_voted;
    assign o_yes_count    = r_yes_count;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_timed_out    = r_timed_out;

endmodule

// File: tb/tb_voter_tally_fsm.sv
// Directed bench for voter_tally_fsm: N=4 and N=5 instances,
// a vector table of single-cycle sessions plus multi-cycle sequences.
module tb_voter_tally_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] vv4 = '0;
    logic [3:0] vy4 = '0;
    logic       busy4;
    logic [3:0] voted4;
    logic [2:0] yc4;
    logic [2:0] res4;
    logic       rv4;
    logic       to4;

    logic       start5 = 1'b0;
    logic [4:0] vv5 = '0;
    logic [4:0] vy5 = '0;
    logic       busy5;
    logic [4:0] voted5;
    logic [2:0] yc5;
    logic [2:0] res5;
    logic       rv5;
    logic       to5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    voter_tally_fsm #(.N_VOTERS(4), .TIMEOUT(16)) dut4 (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start4),
        .i_vote_valid   (vv4),
        .i_vote_yes     (vy4),
        .o_busy         (busy4),
        .o_voted        (voted4),
        .o_yes_count    (yc4),
        .o_result       (res4),
        .o_result_valid (rv4),
        .o_timed_out    (to4)
    );

    voter_tally_fsm #(.N_VOTERS(5), .TIMEOUT(16)) dut5 (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start5),
        .i_vote_valid   (vv5),
        .i_vote_yes     (vy5),
        .o_busy         (busy5),
        .o_voted        (voted5),
        .o_yes_count    (yc5),
        .o_result       (res5),
        .o_result_valid (rv5),
        .o_timed_out    (to5)
    );

    typedef struct {
        logic [3:0] valid;
        logic [3:0] yes;
        logic [2:0] res;
        logic [2:0] yc;
        logic       to;
        logic [3:0] voted;
    } vec_t;

    vec_t tbl [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic vote4(input logic [3:0] v, input logic [3:0] y);
        vv4 = v;
        vy4 = y;
        tick();
        vv4 = '0;
        vy4 = '0;
    endtask

    task automatic vote5(input logic [4:0] v, input logic [4:0] y);
        vv5 = v;
        vy5 = y;
        tick();
        vv5 = '0;
        vy5 = '0;
    endtask

    task automatic open4();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
    endtask

    task automatic open5();
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
    endtask

    task automatic wait_rv4(input string name);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rv4) begin
                ok = 1;
                break;
            end
        end
        chk({name, "_rv_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_rv5(input string name);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rv5) begin
                ok = 1;
                break;
            end
        end
        chk({name, "_rv_seen"}, 32'(ok), 32'd1);
    endtask

    initial begin
        bit seen;

        tbl[0] = '{4'b1111, 4'b0111, 3'b001, 3'd3, 1'b0, 4'b1111};
        tbl[1] = '{4'b1111, 4'b0011, 3'b010, 3'd2, 1'b0, 4'b1111};
        tbl[2] = '{4'b1111, 4'b0001, 3'b100, 3'd1, 1'b0, 4'b1111};
        tbl[3] = '{4'b1111, 4'b1111, 3'b001, 3'd4, 1'b0, 4'b1111};
        tbl[4] = '{4'b1111, 4'b0000, 3'b100, 3'd0, 1'b0, 4'b1111};
        tbl[5] = '{4'b1111, 4'b1010, 3'b010, 3'd2, 1'b0, 4'b1111};
        tbl[6] = '{4'b0011, 4'b0011, 3'b010, 3'd2, 1'b1, 4'b0011};
        tbl[7] = '{4'b0111, 4'b0111, 3'b001, 3'd3, 1'b1, 4'b0111};
        tbl[8] = '{4'b0001, 4'b1111, 3'b100, 3'd1, 1'b1, 4'b0001};

        tick();
        tick();
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_voted", 32'(voted4), 32'd0);
        chk("rst_yc", 32'(yc4), 32'd0);
        chk("rst_res", 32'(res4), 32'd0);
        chk("rst_rv", 32'(rv4), 32'd0);
        chk("rst_to", 32'(to4), 32'd0);
        rst = 1'b0;
        tick();

        // Test 1: exact latency of a single-cycle session
        open4();
        chk("t1_busy", 32'(busy4), 32'd1);
        vote4(4'b1111, 4'b0111);
        chk("t1_rv_early", 32'(rv4), 32'd0);
        tick();
        chk("t1_rv", 32'(rv4), 32'd1);
        chk("t1_res", 32'(res4), 32'b001);
        chk("t1_yc", 32'(yc4), 32'd3);
        chk("t1_to", 32'(to4), 32'd0);
        tick();
        chk("t1_rv_drop", 32'(rv4), 32'd0);
        chk("t1_idle", 32'(busy4), 32'd0);
        chk("t1_res_hold", 32'(res4), 32'b001);

        for (int k = 0; k < 9; k++) begin
            string nm;
            nm = $sformatf("tbl%0d", k);
            open4();
            vote4(tbl[k].valid, tbl[k].yes);
            wait_rv4(nm);
            chk({nm, "_res"}, 32'(res4), 32'(tbl[k].res));
            chk({nm, "_yc"}, 32'(yc4), 32'(tbl[k].yc));
            chk({nm, "_to"}, 32'(to4), 32'(tbl[k].to));
            chk({nm, "_voted"}, 32'(voted4), 32'(tbl[k].voted));
            tick();
        end

        // Test 2: one ballot per cycle
        open4();
        vote4(4'b0001, 4'b0001);
        vote4(4'b0010, 4'b0010);
        vote4(4'b0100, 4'b0000);
        vote4(4'b1000, 4'b0000);
        wait_rv4("t2");
        chk("t2_res", 32'(res4), 32'b010);
        chk("t2_yc", 32'(yc4), 32'd2);
        chk("t2_voted", 32'(voted4), 32'hf);
        tick();

        // Test 3: repeat ballot ignored
        open4();
        vote4(4'b0001, 4'b0001);
        vote4(4'b0001, 4'b0000);
        vote4(4'b1110, 4'b0000);
        wait_rv4("t3");
        chk("t3_yc", 32'(yc4), 32'd1);
        chk("t3_res", 32'(res4), 32'b100);
        tick();

        // Test 4a: timeout lands exactly after the 16th OPEN cycle
        open4();
        vote4(4'b0011, 4'b0011);
        for (int i = 0; i < 14; i++) tick();
        chk("t4a_open15", 32'(busy4), 32'd1);
        tick();
        chk("t4a_decide_rv", 32'(rv4), 32'd0);
        tick();
        chk("t4a_rv", 32'(rv4), 32'd1);
        chk("t4a_res", 32'(res4), 32'b010);
        chk("t4a_to", 32'(to4), 32'd1);
        chk("t4a_voted", 32'(voted4), 32'b0011);
        tick();

        // Test 4b: last voters arrive in the 16th OPEN cycle
        open4();
        vote4(4'b0011, 4'b0011);
        for (int i = 0; i < 14; i++) tick();
        vote4(4'b1100, 4'b0000);
        tick();
        chk("t4b_rv", 32'(rv4), 32'd1);
        chk("t4b_to", 32'(to4), 32'd0);
        chk("t4b_res", 32'(res4), 32'b010);
        chk("t4b_voted", 32'(voted4), 32'hf);
        tick();

        // Test 5: reset mid-session
        open4();
        vote4(4'b0011, 4'b0011);
        chk("t5_yc_pre", 32'(yc4), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", 32'(busy4), 32'd0);
        chk("t5_yc", 32'(yc4), 32'd0);
        chk("t5_voted", 32'(voted4), 32'd0);
        chk("t5_res", 32'(res4), 32'd0);
        seen = rv4;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | rv4;
        end
        chk("t5_no_rv", 32'(seen), 32'd0);
        open4();
        vote4(4'b1111, 4'b1111);
        wait_rv4("t5b");
        chk("t5b_res", 32'(res4), 32'b001);
        tick();

        // Test 6: N=5
        open5();
        vote5(5'b11111, 5'b00111);
        wait_rv5("t6a");
        chk("t6a_res", 32'(res5), 32'b001);
        chk("t6a_yc", 32'(yc5), 32'd3);
        tick();
        open5();
        vote5(5'b11111, 5'b00011);
        wait_rv5("t6b");
        chk("t6b_res", 32'(res5), 32'b100);
        tick();
        open5();
        start5 = 1'b1;
        vote5(5'b00001, 5'b00001);
        start5 = 1'b0;
        vote5(5'b11110, 5'b00110);
        wait_rv5("t6c");
        chk("t6c_yc", 32'(yc5), 32'd3);
        chk("t6c_res", 32'(res5), 32'b001);
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        chk("t6c_idle", 32'(busy5), 32'd0);
        tick();
        chk("t6c_no_restart", 32'(busy5), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/voter_tally_fsm.md
Name: voter_tally_fsm

Overview:
Parametrised, sequential successor to the 4-input majority voter. It opens a voting session on `start` and collects one ballot per voter over multiple cycles. The session closes when every voter has voted or a timeout expires. It then issues a registered one-hot verdict {reject, tie, pass} with a one-cycle valid strobe, and sits between voter front-ends and the decision consumer.

Parameters:
- N_VOTERS, 4, number of voters (2..32).
- TIMEOUT, 16, maximum OPEN-state cycles per session (>=1).
- CNT_W, $clog2(N_VOTERS+1), localparam, tally width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  open a session; honoured only in IDLE.
- vote_valid  in  N_VOTERS  per-voter ballot strobe.
- vote_yes  in  N_VOTERS  per-voter ballot value (1 = yes), qualified by vote_valid.
- busy  out  1  session in progress (state != IDLE).
- voted  out  N_VOTERS  mask of voters whose ballot has been accepted.
- yes_count  out  CNT_W  accepted yes ballots this session.
- result  out  3  one-hot verdict: [2] = reject, [1] = tie, [0] = pass; 000 = none.
- result_valid  out  1  one-cycle strobe, result is new.
- timed_out  out  1  session closed by timeout with voters missing.

Behaviour:
- Reset values: state = IDLE; busy = 0, voted = 0, yes_count = 0, result = 000, result_valid = 0, timed_out = 0. Internal timer = 0.
- Reset mid-session: abort immediately to IDLE with the above values. No result_valid is issued.
- All outputs are registered.
- FSM states: IDLE, OPEN, DECIDE, DONE.
- IDLE:
  - start = 1 -> OPEN.
  - Same edge clears voted, yes_count, timer, timed_out, and result (to 000).
- OPEN:
  - Each cycle, accept voter i if vote_valid[i] && !voted[i]: set voted[i] and add vote_yes[i] to the tally.
  - Multiple voters in one cycle are summed in one cycle.
  - Repeat ballots from a voter who has already voted are ignored; the first ballot counts.
  - The timer increments every OPEN cycle.
  - Next state is DECIDE when the post-update voted mask is all ones, or when timer == TIMEOUT-1.
  - timed_out <= 1 only if closing by timeout with the post-update mask not all ones.
  - All-voted takes priority over a simultaneous timeout: timed_out stays 0.
  - start is ignored.
- DECIDE (one cycle): result is registered from yes_count, with the compare done at CNT_W+1 bits:
  - 2*yes_count > N_VOTERS -> 001 (pass);
  - 2*yes_count == N_VOTERS -> 010 (tie);
  - otherwise -> 100 (reject).
  - Missing voters count as no.
  - Tie is unreachable for odd N_VOTERS.
  - Next state is DONE; result_valid <= 1.
- DONE (one cycle):
  - result_valid = 1 for exactly this cycle; next state is IDLE and result_valid <= 0.
  - result, yes_count, voted and timed_out hold until the next accepted start or reset.
- Latency: last ballot sampled at edge E0 -> DECIDE; edge E1 -> DONE with result_valid visible; edge E2 -> IDLE. Minimum start-to-result_valid is 3 edges.
- vote_valid is ignored in IDLE, DECIDE and DONE. start is ignored in all states except IDLE.
- For N_VOTERS = 4, the verdicts match the legacy 4-input voter truth table.

Decomposition:
- Package voter_pkg holds:
  - result encodings RES_NONE = 3'b000, RES_REJECT = 3'b100, RES_TIE = 3'b010, RES_PASS = 3'b001;
  - state enum {IDLE, OPEN, DECIDE, DONE};
  - a verdict function (yes, n) -> 3-bit one-hot.
- Sub-module voter_popcount, parametrised on N_VOTERS: combinational count of (vote_valid & ~voted & vote_yes), output CNT_W bits.

Test Plan:
1. N = 4: start, then the next cycle vote_valid = 1111, vote_yes = 0111 -> result_valid after 2 further edges; result = 001, yes_count = 3, timed_out = 0, busy low one cycle after the strobe.
2. N = 4: one ballot per cycle — v0 yes, v1 yes, v2 no, v3 no -> result = 010, yes_count = 2, voted = 1111.
3. N = 4: v0 yes, then v0 again with vote_yes = 0, then v1..v3 no -> repeat ignored; yes_count = 1, result = 100.
4. N = 4, TIMEOUT = 16:
   - Only v0, v1 vote yes in cycle 1, then silence -> DECIDE after the 16th OPEN cycle; result = 010, timed_out = 1, voted = 0011.
   - Same setup but v2, v3 vote no in the 16th OPEN cycle -> timed_out = 0, result = 010.
5. Reset mid-OPEN after 2 accepted yes ballots -> next cycle busy = 0, yes_count = 0, voted = 0, result = 000, no result_valid. A subsequent start plus 1111/1111 -> 001.
6. N = 5:
   - 3 yes + 2 no -> 001.
   - 2 yes + 3 no -> 100 (tie never asserted).
   - start pulsed during OPEN and DONE -> ignored, no second session.
